pr_timer: RTL
=============

// Module: pr_timer
// PURPOSE
//   Programmable down-counting timer on the processor peripheral bus. It decodes CPU register
//   writes (address, data, byte enables, write strobe) and returns read data to the CPU.
//   It raises one hardware-interrupt line for the CPU interrupt input (HWInt[2]).
//   Three registers: CTRL (0x0), PRESET (0x4), COUNT (0x8, read-only).
// PARAMETERS
//   CNT_W   32   width of PRESET and COUNT (1..32); DIn/DOut stay 32 bits, zero-extended
// PORTS
//   clk    in   1   system clock, rising edge
//   rst    in   1   asynchronous, active-high reset
//   Addr   in   2   word address [3:2]: 00 CTRL, 01 PRESET, 10 COUNT, 11 unused
//   WE     in   1   write strobe for this device (bridge-decoded), sampled at clk rise
//   BE     in   4   byte enables for writes; BE[i] qualifies DIn[8i+7:8i]
//   DIn    in   32  write data from CPU
//   DOut   out  32  read data to CPU, combinational from Addr
//   IRQ    out  1   interrupt request, registered
// BEHAVIOUR
//   CTRL bits: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM.
//   CTRL bits [31:4] read 0.
//   Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, IRQ=0. DOut follows Addr.
//   Reads: DOut = {0,CTRL[3:0]} | {0,PRESET} | {0,COUNT} | 0 for Addr 00/01/10/11.
//   Reads have no side effects.
//   Writes to CTRL/PRESET update only the enabled bytes. Writes to COUNT or Addr 11 are ignored.
//   Any write to CTRL or PRESET clears irq_flag.
//   Writing PRESET forces state to IDLE on the next cycle (COUNT holds); it restarts via LOAD if EN=1.
//   FSM (registered state):
//     IDLE: EN=1 -> LOAD
//     LOAD: COUNT<=PRESET -> CNT
//     CNT: if COUNT==0 or COUNT==1 then COUNT<=0, irq_flag<=1, -> INT; else COUNT<=COUNT-1
//     INT, one-shot: EN<=0, irq_flag held, -> IDLE
//     INT, auto-reload: irq_flag<=0 next cycle, -> LOAD
//   EN=0 in any state -> IDLE next cycle; COUNT frozen; irq_flag unchanged.
//   IRQ = irq_flag & IM, registered. It rises one cycle after the INT state is entered.
//   One-shot: IRQ stays high until a CTRL or PRESET write.
//   Auto-reload: IRQ is a 1-cycle pulse; period = PRESET+2 cycles for PRESET>=1; PRESET=0 behaves as 1.
//   COUNT never wraps below 0.
//   Simultaneous CPU write to CTRL and FSM clear of EN (INT, one-shot): the CPU write wins.
//   Async reset mid-count: everything returns to reset values immediately.
// STRUCTURE
//   Shared package mips_pr_pkg:
//     register offsets TMR_CTRL/TMR_PRESET/TMR_COUNT
//     MODE encodings (MODE_ONESHOT, MODE_RELOAD)
//     CTRL bit indices
//     state encoding (IDLE, LOAD, CNT, INT)
//   Single flat module; no sub-module is warranted (register file + FSM + down counter).
// TESTING
//   1. Reset then read all 4 addresses -> DOut=0 for each; IRQ=0.
//   2. PRESET=5, CTRL=0x9 (one-shot, IM): LOAD, COUNT 5..1, then INT.
//      IRQ rises 8 cycles after the CTRL write and stays high.
//      CTRL then reads 0x8; a CTRL write clears IRQ next cycle.
//   3. PRESET=3, CTRL=0xB (auto-reload): IRQ pulses 1 cycle wide every 5 cycles;
//      COUNT reloads to 3 after each pulse.
//   4. Partial write: PRESET=0x12345678, then write 0xAAAAAAAA with BE=0100 -> PRESET reads 0x12AA5678.
//      A write to COUNT is ignored.
//   5. Clear EN mid-count at COUNT=7 -> COUNT holds 7, no IRQ.
//      Re-set EN -> reload from PRESET; PRESET write mid-count restarts via IDLE/LOAD.
//   6. Assert rst while COUNT=2 in auto-reload -> all registers 0, IRQ=0 without waiting for clk.

Source files
------------

// File: rtl/mips_pr_pkg.sv
// Shared definitions for the peripheral-bus timer: register map, CTRL layout,
// FSM state encoding and a byte-enable merge helper.
package mips_pr_pkg;

  localparam int unsigned BUS_W = 32;

  localparam logic [1:0] TMR_CTRL   = 2'b00;
  localparam logic [1:0] TMR_PRESET = 2'b01;
  localparam logic [1:0] TMR_COUNT  = 2'b10;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_MODE_HI = 2;
  localparam int unsigned CTRL_IM      = 3;
  localparam int unsigned CTRL_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_CNT  = 2'b10,
    ST_INT  = 2'b11
  } tmr_state_e;

  // Replace each byte of old_v whose enable is set with the matching byte of new_v.
  function automatic logic [BUS_W-1:0] be_merge(input logic [BUS_W-1:0] old_v,
                                                input logic [BUS_W-1:0] new_v,
                                                input logic [3:0]       be);
    logic [BUS_W-1:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/pr_timer.sv
// Programmable down-counting timer: CTRL/PRESET/COUNT register file, a four-state
// load/count/interrupt FSM and a registered interrupt line.
module pr_timer
  import mips_pr_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        Addr,
  input  logic              WE,
  input  logic [3:0]        BE,
  input  logic [BUS_W-1:0]  DIn,
  output logic [BUS_W-1:0]  DOut,
  output logic              IRQ
);

  logic [CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]  preset_q;
  logic [CNT_W-1:0]  count_q;
  logic              irq_flag_q;
  logic              irq_q;
  tmr_state_e        state_q;

  logic              wr_ctrl_c;
  logic              wr_preset_c;
  logic              mode_reload_c;
  logic [CTRL_W-1:0] ctrl_wr_c;
  logic [BUS_W-1:0]  preset_wr_c;

  // CTRL only has live bits in byte 0, so only BE[0] matters for it.
  always_comb begin
    wr_ctrl_c     = WE && (Addr == TMR_CTRL);
    wr_preset_c   = WE && (Addr == TMR_PRESET);
    mode_reload_c = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
    ctrl_wr_c     = BE[0] ? DIn[CTRL_W-1:0] : ctrl_q;
    preset_wr_c   = be_merge(BUS_W'(preset_q), DIn, BE);
  end

  // Read mux; reads never alter state.
  always_comb begin
    DOut = '0;
    case (Addr)
      TMR_CTRL:   DOut = BUS_W'(ctrl_q);
      TMR_PRESET: DOut = BUS_W'(preset_q);
      TMR_COUNT:  DOut = BUS_W'(count_q);
      default:    DOut = '0;
    endcase
  end

  assign IRQ = irq_q;

  // FSM and counter first; CPU writes are applied last so they take precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      irq_q <= irq_flag_q & ctrl_q[CTRL_IM];

      if (!ctrl_q[CTRL_EN]) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_LOAD;
          ST_LOAD: begin
            count_q <= preset_q;
            state_q <= ST_CNT;
          end
          ST_CNT: begin
            if (count_q <= CNT_W'(1)) begin
              count_q    <= '0;
              irq_flag_q <= 1'b1;
              state_q    <= ST_INT;
            end else begin
              count_q <= count_q - CNT_W'(1);
            end
          end
          ST_INT: begin
            if (mode_reload_c) begin
              irq_flag_q <= 1'b0;
              state_q    <= ST_LOAD;
            end else begin
              ctrl_q[CTRL_EN] <= 1'b0;
              state_q         <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end

      if (wr_ctrl_c) begin
        ctrl_q     <= ctrl_wr_c;
        irq_flag_q <= 1'b0;
      end

      // A new PRESET restarts the cycle through IDLE; COUNT is left as is.
      if (wr_preset_c) begin
        preset_q   <= CNT_W'(preset_wr_c);
        irq_flag_q <= 1'b0;
        state_q    <= ST_IDLE;
      end
    end
  end

endmodule
